// File: rtl/rf_write_arbiter_if.sv
// Write-port bundle between the write clients, the arbiter and the 16x16 RegisterFile.
// The master modport is the client/testbench side; the slave modport is the arbiter.
interface rf_write_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16
);
  logic                      clear_req;
  logic                      clear_busy;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rf_regwrite;
  logic [ADDR_W-1:0]         rf_wa;
  logic [DATA_W-1:0]         rf_wd;

  modport master (
    output clear_req, req_valid, req_addr, req_data,
    input  clear_busy, req_ready, rf_regwrite, rf_wa, rf_wd
  );

  modport slave (
    input  clear_req, req_valid, req_addr, req_data,
    output clear_busy, req_ready, rf_regwrite, rf_wa, rf_wd
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single RegisterFile write port, with a zero-fill sweep after reset or on request.
// Optional per-client grant counters are enabled by defining RF_ARB_STAT_EN.
module rf_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_write_arbiter_if.slave    bus
`ifdef RF_ARB_STAT_EN
  ,
  output logic [NUM_REQ*8-1:0] grant_cnt
`endif
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {CLR, ARB} state_t;

  state_t              r_state;
  logic [ADDR_W:0]     r_sweep_cnt;
  logic [RR_W-1:0]     r_rr_last;
  logic                r_regwrite;
  logic [ADDR_W-1:0]   r_wa;
  logic [DATA_W-1:0]   r_wd;
  logic                r_busy;

  logic [NUM_REQ-1:0]  w_grant;
  logic                w_found;
  logic                w_fire;
  logic [RR_W-1:0]     w_gidx;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;

  // Scan clients starting just after the last winner; first valid one wins.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_grant = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && bus.req_valid[(int'(r_rr_last) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_gidx  = RR_W'((int'(r_rr_last) + k) % NUM_REQ);
      end
    end
    w_fire = (r_state == ARB) && !bus.clear_req && w_found;
    if (w_fire) w_grant[w_gidx] = 1'b1;
  end

  assign w_sel_addr = bus.req_addr[w_gidx*ADDR_W +: ADDR_W];
  assign w_sel_data = bus.req_data[w_gidx*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CLR;
      r_sweep_cnt <= '0;
      r_rr_last   <= RR_W'(NUM_REQ - 1);
      r_regwrite  <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_busy      <= 1'b1;
    end else begin
      case (r_state)
        CLR: begin
          r_regwrite <= 1'b1;
          r_wa       <= r_sweep_cnt[ADDR_W-1:0];
          r_wd       <= '0;
          r_busy     <= 1'b1;
          if (r_sweep_cnt == (ADDR_W+1)'(DEPTH - 1)) begin
            r_state     <= ARB;
            r_sweep_cnt <= '0;
          end else begin
            r_sweep_cnt <= r_sweep_cnt + 1'b1;
          end
        end
        ARB: begin
          r_busy <= 1'b0;
          if (bus.clear_req) begin
            r_state     <= CLR;
            r_sweep_cnt <= '0;
            r_regwrite  <= 1'b0;
            r_busy      <= 1'b1;
          end else if (w_fire) begin
            r_regwrite <= 1'b1;
            r_wa       <= w_sel_addr;
            r_wd       <= w_sel_data;
            r_rr_last  <= w_gidx;
          end else begin
            r_regwrite <= 1'b0;
          end
        end
        default: r_state <= CLR;
      endcase
    end
  end

  assign bus.req_ready   = w_grant;
  assign bus.rf_regwrite = r_regwrite;
  assign bus.rf_wa       = r_wa;
  assign bus.rf_wd       = r_wd;
  assign bus.clear_busy  = r_busy;

`ifdef RF_ARB_STAT_EN
  // Saturating per-client grant counters, zeroed on reset and whenever a sweep starts.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    logic [7:0] r_cnt;
    always_ff @(posedge clk) begin
      if (rst || (r_state == ARB && bus.clear_req)) begin
        r_cnt <= '0;
      end else if (w_grant[gi] && r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
    assign grant_cnt[gi*8 +: 8] = r_cnt;
  end
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter: sweep, single grants, round-robin, clear during request, reset mid-sweep.
// Grant-counter checks are compiled in only when RF_ARB_STAT_EN is defined.
module tb_rf_write_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 16;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  logic [DATA_W-1:0] rf_model [16];

  rf_write_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef RF_ARB_STAT_EN
  logic [NUM_REQ*8-1:0] grant_cnt;
`endif

  rf_write_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RF_ARB_STAT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model driven by the arbiter outputs, one line per write.
  always @(posedge clk) begin
    if (bus.rf_regwrite) begin
      rf_model[bus.rf_wa] <= bus.rf_wd;
      $display("write  rf_wa=%0d rf_wd=0x%04h", bus.rf_wa, bus.rf_wd);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk({tag, "_we"}, 32'(bus.rf_regwrite), 32'd1);
      chk({tag, "_wa"}, 32'(bus.rf_wa), 32'(i));
      chk({tag, "_wd"}, 32'(bus.rf_wd), 32'd0);
      chk({tag, "_busy"}, 32'(bus.clear_busy), 32'd1);
    end
  endtask

  // Single-client write: valid set at negedge, ready checked, write checked next cycle.
  task automatic single_write(input int c, input logic [3:0] a, input logic [15:0] d);
    bus.req_addr[c*ADDR_W +: ADDR_W] = a;
    bus.req_data[c*DATA_W +: DATA_W] = d;
    bus.req_valid = 2'(1 << c);
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'(1 << c));
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    chk("single_we", 32'(bus.rf_regwrite), 32'd1);
    chk("single_wa", 32'(bus.rf_wa), 32'(a));
    chk("single_wd", 32'(bus.rf_wd), 32'(d));
    $display("grant  client=%0d addr=%0d data=0x%04h", c, a, d);
  endtask

  initial begin
    int exp_g;
    logic [15:0] exp_d;
    logic [3:0]  exp_a;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.clear_req = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;

    // 1: reset, then the 16-write sweep with clients requesting (must not be granted)
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 32'(bus.rf_regwrite), 32'd0);
    chk("rst_wa", 32'(bus.rf_wa), 32'd0);
    chk("rst_busy", 32'(bus.clear_busy), 32'd1);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("sweep_we", 32'(bus.rf_regwrite), 32'd1);
      chk("sweep_wa", 32'(bus.rf_wa), 32'(i));
      chk("sweep_wd", 32'(bus.rf_wd), 32'd0);
      chk("sweep_busy", 32'(bus.clear_busy), 32'd1);
      if (i < 15) chk("sweep_ready", 32'(bus.req_ready), 32'd0);
      if (i == 14) bus.req_valid = '0;
    end
    @(negedge clk);
    chk("post_sweep_we", 32'(bus.rf_regwrite), 32'd0);
    chk("post_sweep_busy", 32'(bus.clear_busy), 32'd0);

    // 2: client0 alone, then idle holds wa/wd
    single_write(0, 4'd3, 16'h1234);
    @(negedge clk);
    chk("idle_we", 32'(bus.rf_regwrite), 32'd0);
    chk("idle_wa_hold", 32'(bus.rf_wa), 32'd3);
    chk("idle_wd_hold", 32'(bus.rf_wd), 32'h1234);
    // client1 alone puts the round-robin pointer back on client1
    single_write(1, 4'd5, 16'h5555);

    // 3: both clients valid every cycle, alternate grants starting with client0
    bus.req_addr = {4'd2, 4'd1};
    bus.req_data = {16'hB000, 16'hA000};
    bus.req_valid = 2'b11;
    exp_g = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_ready", 32'(bus.req_ready), 32'(1 << exp_g));
      exp_d = (exp_g == 0) ? bus.req_data[15:0] : bus.req_data[31:16];
      exp_a = (exp_g == 0) ? 4'd1 : 4'd2;
      @(posedge clk);
      #1;
      if (exp_g == 0) bus.req_data[15:0] = 16'hA001 + 16'(i);
      else            bus.req_data[31:16] = 16'hB001 + 16'(i);
      @(negedge clk);
      chk("rr_we", 32'(bus.rf_regwrite), 32'd1);
      chk("rr_wa", 32'(bus.rf_wa), 32'(exp_a));
      chk("rr_wd", 32'(bus.rf_wd), 32'(exp_d));
      $display("grant  client=%0d addr=%0d data=0x%04h", exp_g, exp_a, exp_d);
      exp_g = 1 - exp_g;
    end
    bus.req_valid = '0;
    @(negedge clk);

    // 4: client1 request coincides with clear_req -> sweep first, then grant
    bus.req_addr[7:4] = 4'd9;
    bus.req_data[31:16] = 16'hBEEF;
    bus.req_valid = 2'b10;
    bus.clear_req = 1'b1;
    #1;
    chk("clr_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 bus.clear_req = 1'b0;
    @(negedge clk);
    chk("clr_we", 32'(bus.rf_regwrite), 32'd0);
    chk("clr_busy", 32'(bus.clear_busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("clr_sweep_wa", 32'(bus.rf_wa), 32'(i));
      chk("clr_sweep_we", 32'(bus.rf_regwrite), 32'd1);
      chk("clr_sweep_ready", 32'(bus.req_ready), (i < 15) ? 32'd0 : 32'd2);
    end
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    chk("clr_grant_wa", 32'(bus.rf_wa), 32'd9);
    chk("clr_grant_wd", 32'(bus.rf_wd), 32'hBEEF);
    @(negedge clk);
    chk("reg9_value", 32'(rf_model[9]), 32'hBEEF);
    chk("reg3_cleared", 32'(rf_model[3]), 32'd0);

    // 5: reset while the sweep is at address 7 restarts it from 0
    bus.clear_req = 1'b1;
    @(posedge clk);
    #1 bus.clear_req = 1'b0;
    @(negedge clk);
    repeat (8) @(negedge clk);
    chk("mid_sweep_wa", 32'(bus.rf_wa), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_we", 32'(bus.rf_regwrite), 32'd0);
    chk("mid_rst_wa", 32'(bus.rf_wa), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_sweep("resweep");
    @(negedge clk);
    chk("resweep_done_busy", 32'(bus.clear_busy), 32'd0);

`ifdef RF_ARB_STAT_EN
    // 6: grant counters saturate and clear on sweep entry
    single_write(1, 4'd4, 16'h0044);
    bus.req_addr[3:0] = 4'd6;
    bus.req_data[15:0] = 16'h0066;
    bus.req_valid = 2'b01;
    repeat (300) @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    chk("cnt0_sat", 32'(grant_cnt[7:0]), 32'd255);
    chk("cnt1_keep", 32'(grant_cnt[15:8]), 32'd1);
    bus.clear_req = 1'b1;
    @(posedge clk);
    #1 bus.clear_req = 1'b0;
    @(negedge clk);
    chk("cnt0_clr", 32'(grant_cnt[7:0]), 32'd0);
    chk("cnt1_clr", 32'(grant_cnt[15:8]), 32'd0);
    repeat (20) @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
